branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Direct-mapped branch target buffer with 2-bit saturating direction counters and mispredict/flush control for the 5-stage pipeline. It predicts taken/target in IF from the fetch PC. In EX it compares the prediction against the branch comparator's resolved `ex_BrEn` and the ALU-computed target, raises the pipeline flush and PC redirect, and trains the table. It also keeps saturating performance counters for resolved branches and mispredicts.

## Interface
Parameters:
- `IDX_W`, 4, index width; table holds 2^IDX_W entries, indexed by PC[IDX_W+1:2]
- `CNT_W`, 32, width of each performance counter

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `if_PC`  input  32  current fetch PC
- `if_PredTaken`  output  1  predict taken for `if_PC`
- `if_PredTarget`  output  32  predicted target; 0 when `if_PredTaken`=0
- `ex_Valid`  input  1  EX holds a real instruction (not a bubble)
- `ex_IsBranch`  input  1  EX instruction is a conditional branch (ImmSel = B-type)
- `ex_Stall`  input  1  EX is held this cycle
- `ex_PC`  input  32  PC of EX instruction
- `ex_PredTaken`  input  1  prediction carried down the pipe with the instruction
- `ex_PredTarget`  input  32  predicted target carried down the pipe
- `ex_BrEn`  input  1  resolved taken, from the branch comparator
- `ex_BrTarget`  input  32  resolved target (PC + B-imm)
- `ex_Flush`  output  1  kill IF/ID and ID/EX contents this cycle
- `ex_PCSel`  output  1  1 = next PC comes from `ex_RedirectPC`
- `ex_RedirectPC`  output  32  corrected next PC
- `BrCount`  output  CNT_W  resolved branches
- `MissCount`  output  CNT_W  mispredicted branches

## Operation
- Entry fields: `valid`, `tag` = PC[31:IDX_W+2], `target` [31:0], `ctr` [1:0].
  - `ctr` encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Prediction (combinational on `if_PC`):
  - hit = `valid` and tag match.
  - `if_PredTaken` = hit and `ctr`[1].
  - `if_PredTarget` = `target` when `if_PredTaken`, else 0.
- Resolve condition: R = `ex_Valid` & `ex_IsBranch` & !`ex_Stall`.
- Mispredict: M = R & ((`ex_BrEn` != `ex_PredTaken`) | (`ex_BrEn` & `ex_PredTaken` & `ex_PredTarget` != `ex_BrTarget`)).
- Outputs under M:
  - `ex_Flush` = `ex_PCSel` = M.
  - `ex_RedirectPC` = `ex_BrEn` ? `ex_BrTarget` : `ex_PC`+4 (modulo 2^32); value is don't-care when M=0, driven 0.
- Training, on clock edge when R, at index of `ex_PC`:
  - Tag hit: `ctr` ±1, saturating at 00/11. If taken, rewrite `target`.
  - Tag miss, taken: allocate (overwrite) with `valid`=1, new tag, `target`=`ex_BrTarget`, `ctr`=10.
  - Tag miss, not taken: no write.
- Perf counters, on clock edge:
  - `BrCount` +1 when R.
  - `MissCount` +1 when M.
  - Both saturate at all-ones; no wrap.
- Non-branch, bubble, or stalled EX: no table write, no counter change, `ex_Flush`=0.

## Timing
- Reset (async, immediate): every `valid`=0, `ctr`=01, `target`=0, tag=0, `BrCount`=`MissCount`=0.
  - While `rst`=1: `if_PredTaken`=0, `if_PredTarget`=0, `ex_Flush`=0, `ex_PCSel`=0, `ex_RedirectPC`=0, regardless of inputs.
- Prediction latency: 0 cycles (same-cycle read of registered table).
- Flush/redirect: same cycle as resolution in EX (combinational from EX inputs); the pipeline takes the redirect at the next edge.
- Table update visible to `if_PC` lookups from the cycle after the training edge.
- Same-index read in IF and write from EX in one cycle: IF sees the old entry; no bypass.
- Stall: a branch stalled in EX resolves only in the first non-stalled cycle, exactly once.
- Reset mid-operation: pending training is discarded; counters clear immediately.

## Test plan
- Reset, then `if_PC`=0x100 → `if_PredTaken`=0, `if_PredTarget`=0. Assert `rst` with M conditions on the EX inputs → `ex_Flush`=0.
- Cold branch at 0x100, `ex_PredTaken`=0, `ex_BrEn`=1, target 0x80 → `ex_Flush`=1, `ex_RedirectPC`=0x80, `MissCount`=1. Next cycle `if_PC`=0x100 → `if_PredTaken`=1, `if_PredTarget`=0x80.
- Entry at 0x100 with ctr=10, resolved not-taken twice → first: `ex_RedirectPC`=0x104, ctr 01. Second (`ex_PredTaken`=0): no flush, ctr 00. Four taken resolutions then saturate ctr at 11.
- Predicted taken to 0x80, resolved taken to 0x90 → `ex_Flush`=1, `ex_RedirectPC`=0x90. Entry target becomes 0x90.
- Aliasing: 0x100 trained taken, then 0x140 (IDX_W=4, same index) resolved taken → entry retagged. Lookup of 0x100 → `if_PredTaken`=0.
- Branch with `ex_Stall`=1 for 3 cycles then 0 → `BrCount` increments by exactly 1, flush only in the final cycle. Force `BrCount` near saturation with back-to-back branches → holds at all-ones.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit direction counters, EX-stage mispredict detection,
// flush/redirect generation, table training and saturating branch/miss counters.
module branch_predict_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_PC,
  output logic             if_PredTaken,
  output logic [31:0]      if_PredTarget,
  input  logic             ex_Valid,
  input  logic             ex_IsBranch,
  input  logic             ex_Stall,
  input  logic [31:0]      ex_PC,
  input  logic             ex_PredTaken,
  input  logic [31:0]      ex_PredTarget,
  input  logic             ex_BrEn,
  input  logic [31:0]      ex_BrTarget,
  output logic             ex_Flush,
  output logic             ex_PCSel,
  output logic [31:0]      ex_RedirectPC,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned TagW    = 30 - IDX_W;

  logic            valid_q  [Entries];
  logic [TagW-1:0] tag_q    [Entries];
  logic [31:0]     target_q [Entries];
  logic [1:0]      ctr_q    [Entries];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TagW-1:0]  if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             resolve, mispredict;
  logic             unused_pc_bits;

  assign if_idx = if_PC[IDX_W+1:2];
  assign if_tag = if_PC[31:IDX_W+2];
  assign ex_idx = ex_PC[IDX_W+1:2];
  assign ex_tag = ex_PC[31:IDX_W+2];
  assign unused_pc_bits = ^{if_PC[1:0], ex_PC[1:0]};

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign resolve    = ex_Valid && ex_IsBranch && !ex_Stall;
  assign mispredict = resolve && ((ex_BrEn != ex_PredTaken) ||
                      (ex_BrEn && ex_PredTaken && (ex_PredTarget != ex_BrTarget)));

  // Outputs are forced low while reset is held, independent of EX inputs.
  always_comb begin
    if_PredTaken  = 1'b0;
    if_PredTarget = 32'h0;
    ex_Flush      = 1'b0;
    ex_PCSel      = 1'b0;
    ex_RedirectPC = 32'h0;
    if (!rst) begin
      if_PredTaken  = if_hit && ctr_q[if_idx][1];
      if_PredTarget = if_PredTaken ? target_q[if_idx] : 32'h0;
      ex_Flush      = mispredict;
      ex_PCSel      = mispredict;
      if (mispredict) begin
        ex_RedirectPC = ex_BrEn ? ex_BrTarget : (ex_PC + 32'd4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (resolve) begin
      if (ex_hit) begin
        if (ex_BrEn) begin
          ctr_q[ex_idx]    <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= ex_BrTarget;
        end else begin
          ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_BrEn) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_BrTarget;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else begin
      if (resolve && (BrCount != '1)) begin
        BrCount <= BrCount + CNT_W'(1);
      end
      if (mispredict && (MissCount != '1)) begin
        MissCount <= MissCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed vector table for the BTB corner cases, then randomized traffic checked
// against a per-branch-address behavioural model of the predictor.
module tb_branch_predict_ctrl;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      if_PC;
  logic             if_PredTaken;
  logic [31:0]      if_PredTarget;
  logic             ex_Valid, ex_IsBranch, ex_Stall, ex_PredTaken, ex_BrEn;
  logic [31:0]      ex_PC, ex_PredTarget, ex_BrTarget;
  logic             ex_Flush, ex_PCSel;
  logic [31:0]      ex_RedirectPC;
  logic [CNT_W-1:0] BrCount, MissCount;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_PC(if_PC), .if_PredTaken(if_PredTaken),
    .if_PredTarget(if_PredTarget), .ex_Valid(ex_Valid), .ex_IsBranch(ex_IsBranch),
    .ex_Stall(ex_Stall), .ex_PC(ex_PC), .ex_PredTaken(ex_PredTaken),
    .ex_PredTarget(ex_PredTarget), .ex_BrEn(ex_BrEn), .ex_BrTarget(ex_BrTarget),
    .ex_Flush(ex_Flush), .ex_PCSel(ex_PCSel), .ex_RedirectPC(ex_RedirectPC),
    .BrCount(BrCount), .MissCount(MissCount)
  );

  typedef struct {
    logic        r;
    logic [31:0] ifpc;
    logic        v, b, s;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptg;
    logic        en;
    logic [31:0] tg;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_fl;
    logic [31:0] e_rd;
    int          e_br, e_mi;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic [31:0] ifpc, logic v, logic b, logic s,
                              logic [31:0] pc, logic pt, logic [31:0] ptg, logic en,
                              logic [31:0] tg, logic e_pt, logic [31:0] e_ptg,
                              logic e_fl, logic [31:0] e_rd, int e_br, int e_mi);
    vec_t x;
    x.r = r; x.ifpc = ifpc; x.v = v; x.b = b; x.s = s; x.pc = pc; x.pt = pt;
    x.ptg = ptg; x.en = en; x.tg = tg; x.e_pt = e_pt; x.e_ptg = e_ptg;
    x.e_fl = e_fl; x.e_rd = e_rd; x.e_br = e_br; x.e_mi = e_mi;
    return x;
  endfunction

  // Behavioural model: each slot remembers the full PC of the branch that owns it.
  bit          m_valid [16];
  logic [31:0] m_owner [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_br, m_mi;

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit owns(logic [31:0] pc);
    int i = slot(pc);
    return m_valid[i] && ((m_owner[i] / 64) == (pc / 64));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mi = 0;
  endtask

  initial begin
    int i0;
    logic        e_pt, e_fl, r, m;
    logic [31:0] e_ptg, e_rd;

    // Directed table
    vecs.push_back(mk(1, 32'h100, 1,1,0, 32'h100, 0,0, 1,32'h80,  0,0, 0,0, 0,0));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 0,0, 1,32'h80,  0,0, 1,32'h80, 0,0));
    vecs.push_back(mk(0, 32'h100, 0,0,0, 0, 0,0, 0,0,             1,32'h80, 0,0, 1,1));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 1,32'h80, 0,32'h80, 1,32'h80, 1,32'h104, 1,1));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 0,0, 0,32'h80,  0,0, 0,0, 2,2));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 0,0, 1,32'h80,  0,0, 1,32'h80, 3,2));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 0,0, 1,32'h80,  0,0, 1,32'h80, 4,3));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 1,32'h80, 1,32'h80, 1,32'h80, 0,0, 5,4));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 1,32'h80, 1,32'h80, 1,32'h80, 0,0, 6,4));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 1,32'h80, 0,32'h80, 1,32'h80, 1,32'h104, 7,4));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h100, 1,32'h80, 1,32'h90, 1,32'h80, 1,32'h90, 8,5));
    vecs.push_back(mk(0, 32'h100, 1,1,0, 32'h140, 0,0, 1,32'h200, 1,32'h90, 1,32'h200, 9,6));
    vecs.push_back(mk(0, 32'h100, 0,0,0, 0, 0,0, 0,0,             0,0, 0,0, 10,7));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 32'h140, 1,1,1, 32'h140, 1,32'h200, 0,0, 1,32'h200, 0,0, 10,7));
    vecs.push_back(mk(0, 32'h140, 1,1,0, 32'h140, 1,32'h200, 0,0, 1,32'h200, 1,32'h144, 10,7));
    vecs.push_back(mk(0, 32'h140, 1,0,0, 32'h140, 0,0, 1,32'h300, 0,0, 0,0, 11,8));
    vecs.push_back(mk(0, 32'h140, 0,1,0, 32'h140, 0,0, 1,32'h300, 0,0, 0,0, 11,8));
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(0, 32'h0, 1,1,0, 32'h208, 0,0, 1,32'h400, 0,0, 1,32'h400,
                        (11 + k > CMAX) ? CMAX : 11 + k, (8 + k > CMAX) ? CMAX : 8 + k));
    vecs.push_back(mk(0, 32'h208, 0,0,0, 0, 0,0, 0,0,             1,32'h400, 0,0, 15,15));
    vecs.push_back(mk(1, 32'h208, 1,1,0, 32'h208, 0,0, 1,32'h500, 0,0, 0,0, 0,0));
    vecs.push_back(mk(0, 32'h208, 0,0,0, 0, 0,0, 0,0,             0,0, 0,0, 0,0));

    rst = 1'b1; if_PC = 0; ex_Valid = 0; ex_IsBranch = 0; ex_Stall = 0; ex_PC = 0;
    ex_PredTaken = 0; ex_PredTarget = 0; ex_BrEn = 0; ex_BrTarget = 0;
    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      rst = vecs[i].r; if_PC = vecs[i].ifpc; ex_Valid = vecs[i].v; ex_IsBranch = vecs[i].b;
      ex_Stall = vecs[i].s; ex_PC = vecs[i].pc; ex_PredTaken = vecs[i].pt;
      ex_PredTarget = vecs[i].ptg; ex_BrEn = vecs[i].en; ex_BrTarget = vecs[i].tg;
      #3;
      check($sformatf("row%0d if_PredTaken", i), {31'b0, if_PredTaken}, {31'b0, vecs[i].e_pt});
      check($sformatf("row%0d if_PredTarget", i), if_PredTarget, vecs[i].e_ptg);
      check($sformatf("row%0d ex_Flush", i), {31'b0, ex_Flush}, {31'b0, vecs[i].e_fl});
      check($sformatf("row%0d ex_PCSel", i), {31'b0, ex_PCSel}, {31'b0, vecs[i].e_fl});
      check($sformatf("row%0d ex_RedirectPC", i), ex_RedirectPC, vecs[i].e_rd);
      check($sformatf("row%0d BrCount", i), 32'(BrCount), 32'(vecs[i].e_br));
      check($sformatf("row%0d MissCount", i), 32'(MissCount), 32'(vecs[i].e_mi));
      @(posedge clk);
    end

    // Randomized traffic against the model; table is freshly reset here.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      #1;
      if_PC       = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2);
      ex_PC       = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2);
      ex_Valid    = ($urandom_range(0, 99) < 85);
      ex_IsBranch = ($urandom_range(0, 99) < 75);
      ex_Stall    = ($urandom_range(0, 99) < 20);
      ex_BrEn     = $urandom_range(0, 1);
      ex_BrTarget = 32'h1000 + ($urandom_range(0, 3) << 4);
      i0 = slot(ex_PC);
      if ($urandom_range(0, 3) != 0) begin
        ex_PredTaken  = owns(ex_PC) && (m_ctr[i0] >= 2);
        ex_PredTarget = ex_PredTaken ? m_tgt[i0] : 32'h0;
      end else begin
        ex_PredTaken  = $urandom_range(0, 1);
        ex_PredTarget = 32'h1000 + ($urandom_range(0, 3) << 4);
      end
      #3;
      e_pt  = owns(if_PC) && (m_ctr[slot(if_PC)] >= 2);
      e_ptg = e_pt ? m_tgt[slot(if_PC)] : 32'h0;
      r     = ex_Valid && ex_IsBranch && !ex_Stall;
      m     = r && ((ex_BrEn != ex_PredTaken) ||
                    (ex_BrEn && ex_PredTaken && ex_PredTarget != ex_BrTarget));
      e_fl  = m;
      e_rd  = !m ? 32'h0 : (ex_BrEn ? ex_BrTarget : ex_PC + 32'd4);
      check("rand if_PredTaken", {31'b0, if_PredTaken}, {31'b0, e_pt});
      check("rand if_PredTarget", if_PredTarget, e_ptg);
      check("rand ex_Flush", {31'b0, ex_Flush}, {31'b0, e_fl});
      check("rand ex_PCSel", {31'b0, ex_PCSel}, {31'b0, e_fl});
      check("rand ex_RedirectPC", ex_RedirectPC, e_rd);
      check("rand BrCount", 32'(BrCount), 32'(m_br));
      check("rand MissCount", 32'(MissCount), 32'(m_mi));
      if (r) begin
        if (owns(ex_PC)) begin
          if (ex_BrEn) begin
            m_ctr[i0] = (m_ctr[i0] + 1 > 3) ? 3 : m_ctr[i0] + 1;
            m_tgt[i0] = ex_BrTarget;
          end else begin
            m_ctr[i0] = (m_ctr[i0] - 1 < 0) ? 0 : m_ctr[i0] - 1;
          end
        end else if (ex_BrEn) begin
          m_valid[i0] = 1; m_owner[i0] = ex_PC; m_tgt[i0] = ex_BrTarget; m_ctr[i0] = 2;
        end
        if (m_br < CMAX) m_br++;
      end
      if (m && m_mi < CMAX) m_mi++;
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
